mips_dmem_io: RTL and testbench

- Data-side stage directly downstream of the CPU core. It consumes aluout as the address, writedata and memwrite, and it returns readdata in the same cycle.
- Contains a word-addressed data RAM, plus memory-mapped I/O: debounced switch inputs, sticky switch-edge flags, an output register driving switchout, and an optional free-running timer.
- Sits beside the instruction ROM in the top level. It replaces the direct switchin/switchout wiring to the core.

---
 rtl/mips_dmem_io_pkg.sv | 39 +++
 rtl/mips_dmem_io_switch_debounce.sv | 45 ++++
 rtl/mips_dmem_io.sv | 92 +++++++++
 tb/tb_mips_dmem_io.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_dmem_io_pkg.sv
// Shared constants, region-select type and address decoder for the mips_dmem_io data-side stage.
package mips_io_pkg;

  localparam int DATA_W   = 16;
  localparam int DECODE_W = 8;

  localparam logic [DECODE_W-1:0] ADDR_SWSTAT = 8'h80;
  localparam logic [DECODE_W-1:0] ADDR_OUTREG = 8'h81;
  localparam logic [DECODE_W-1:0] ADDR_TIMER  = 8'h82;
  localparam logic [DECODE_W-1:0] ADDR_SWEDGE = 8'h83;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_SWSTAT,
    SEL_OUTREG,
    SEL_TIMER,
    SEL_SWEDGE,
    SEL_NONE
  } sel_e;

  // The lower half of the decode space is RAM; the upper half holds the I/O registers.
  function automatic sel_e decode_sel(input logic [DECODE_W-1:0] a);
    sel_e sel;
    sel = SEL_NONE;
    if (!a[DECODE_W-1]) begin
      sel = SEL_RAM;
    end else begin
      case (a)
        ADDR_SWSTAT: sel = SEL_SWSTAT;
        ADDR_OUTREG: sel = SEL_OUTREG;
        ADDR_TIMER:  sel = SEL_TIMER;
        ADDR_SWEDGE: sel = SEL_SWEDGE;
        default:     sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/mips_dmem_io_switch_debounce.sv
// One switch bit: 2-flop synchronizer followed by a stability counter that accepts a change
// after DEBOUNCE_CYCLES consecutive disagreeing samples.
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;
  logic          accept;

  assign accept = (sync2 != level) && (cnt == LAST);
  assign rise   = accept && sync2;

  // NOTE: sequential state uses non-blocking assignments so the two synchronizer flops shift
  // rather than collapsing into one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mips_dmem_io.sv
// Data RAM plus memory-mapped switch/LED/timer I/O beside the core's data port.
// Define MIPS_IO_TIMER_EN to build the free-running TIMER register at 0x82.
module mips_dmem_io
  import mips_io_pkg::*;
#(
  parameter int RAM_AW          = 7,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SW_W            = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memwrite,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  input  logic [SW_W-1:0]   switchin,
  output logic [DATA_W-1:0] switchout
);

  sel_e              sel;
  logic              wr_en;
  logic [SW_W-1:0]   sw_deb, sw_rise;
  logic [SW_W-1:0]   swedge;
  logic [DATA_W-1:0] timer;
  logic [DATA_W-1:0] ram [2**RAM_AW];
  logic              unused_addr_hi;

  assign sel            = decode_sel(addr[DECODE_W-1:0]);
  assign wr_en          = reset && memwrite;
  assign unused_addr_hi = ^addr[DATA_W-1:DECODE_W];

  // NOTE: the RAM array has no reset branch; clearing a memory on reset would force it into
  // flops instead of a RAM macro.
  always_ff @(posedge clk) begin
    if (wr_en && sel == SEL_RAM)
      ram[addr[RAM_AW-1:0]] <= writedata;
  end

  for (genvar i = 0; i < SW_W; i++) begin : g_sw
    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk   (clk),
      .reset (reset),
      .pin   (switchin[i]),
      .level (sw_deb[i]),
      .rise  (sw_rise[i])
    );
  end

  // A new rising edge is ORed in after the write-1-to-clear mask, so set wins over clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      switchout <= '0;
      swedge    <= '0;
    end else begin
      if (wr_en && sel == SEL_OUTREG)
        switchout <= writedata;
      if (wr_en && sel == SEL_SWEDGE)
        swedge <= (swedge & ~writedata[SW_W-1:0]) | sw_rise;
      else
        swedge <= swedge | sw_rise;
    end
  end

`ifdef MIPS_IO_TIMER_EN
  always_ff @(posedge clk) begin
    if (!reset)
      timer <= '0;
    else if (wr_en && sel == SEL_TIMER)
      timer <= '0;
    else
      timer <= timer + DATA_W'(1);
  end
`else
  assign timer = '0;
`endif

  // NOTE: readdata gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    readdata = '0;
    if (reset) begin
      case (sel)
        SEL_RAM:    readdata = ram[addr[RAM_AW-1:0]];
        SEL_SWSTAT: readdata = DATA_W'(sw_deb);
        SEL_OUTREG: readdata = switchout;
        SEL_TIMER:  readdata = timer;
        SEL_SWEDGE: readdata = DATA_W'(swedge);
        default:    readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_dmem_io.sv
// Directed plus randomized bench for mips_dmem_io against a behavioural address-map model.
module tb_mips_dmem_io;

  localparam int DB = 16;

  logic        clk, reset, memwrite;
  logic [15:0] addr, writedata, readdata, switchout;
  logic [2:0]  switchin;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  logic [15:0] m_ram [128];
  logic [15:0] m_out   = '0;
  logic [15:0] m_timer = '0;
  logic [2:0]  m_deb   = '0;
  logic [2:0]  m_edge  = '0;
  logic [2:0]  samp [$];   // effective pin sample seen at each past clock edge

  mips_dmem_io dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .addr      (addr),
    .writedata (writedata),
    .readdata  (readdata),
    .switchin  (switchin),
    .switchout (switchout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // A switch bit flips once its last DB synchronized samples (taken 2..DB+1 edges ago) all disagree.
  function automatic void model_edge(input logic rst, input logic we, input logic [15:0] a,
                                     input logic [15:0] wd, input logic [2:0] sw);
    logic [2:0] new_deb, rise;
    logic [7:0] a8;
    a8 = a[7:0];
    if (!rst) begin
      m_out = '0; m_timer = '0; m_deb = '0; m_edge = '0;
      samp.push_back(3'b000);
    end else begin
      new_deb = m_deb;
      for (int b = 0; b < 3; b++) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int k = 2; k <= DB + 1; k++)
          if (samp[samp.size() - k][b] == m_deb[b]) all_diff = 1'b0;
        if (all_diff) new_deb[b] = ~m_deb[b];
      end
      rise  = new_deb & ~m_deb;
      m_deb = new_deb;
      if (we && a8 < 8'h80) m_ram[a8[6:0]] = wd;
      if (we && a8 == 8'h81) m_out = wd;
      if (we && a8 == 8'h83) m_edge = m_edge & ~wd[2:0];
      m_edge = m_edge | rise;
`ifdef MIPS_IO_TIMER_EN
      if (we && a8 == 8'h82) m_timer = '0;
      else                   m_timer = m_timer + 16'd1;
`endif
      samp.push_back(sw);
    end
    if (samp.size() > DB + 2) void'(samp.pop_front());
  endfunction

  function automatic logic [15:0] exp_rd();
    if (!reset) return 16'h0000;
    case (addr[7:0])
      8'h80:   return {13'b0, m_deb};
      8'h81:   return m_out;
      8'h82:   return m_timer;
      8'h83:   return {13'b0, m_edge};
      default: return addr[7] ? 16'h0000 : m_ram[addr[6:0]];
    endcase
  endfunction

  task automatic tick();
    logic        c_rst, c_we;
    logic [15:0] c_a, c_wd;
    logic [2:0]  c_sw;
    c_rst = reset; c_we = memwrite; c_a = addr; c_wd = writedata; c_sw = switchin;
    @(posedge clk);
    model_edge(c_rst, c_we, c_a, c_wd, c_sw);
    #2;
  endtask

  task automatic drive(input logic we, input logic [15:0] a, input logic [15:0] wd);
    memwrite = we; addr = a; writedata = wd;
    #1;
  endtask

  initial begin
    logic [15:0] t0, ra;
    int hold;
    for (int i = 0; i < DB + 2; i++) samp.push_back(3'b000);

    // Reset with a pending OUTREG store that must be ignored
    reset = 1'b0; switchin = 3'b000;
    drive(1'b1, 16'h0081, 16'hBEEF);
    check("rd_in_reset_t0", readdata, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("switchout_in_reset", switchout, 16'h0000);
      check("rd_in_reset", readdata, 16'h0000);
    end
    reset = 1'b1;
    drive(1'b0, 16'h0081, 16'h0000);
    check("outreg_after_reset", readdata, 16'h0000);

    // RAM basics and read-during-write
    drive(1'b1, 16'h0005, 16'h1234); tick();
    drive(1'b1, 16'h007F, 16'hABCD); tick();
    drive(1'b0, 16'h0005, 16'h0000); check("ram_05", readdata, 16'h1234);
    drive(1'b0, 16'h007F, 16'h0000); check("ram_7f", readdata, 16'hABCD);
    drive(1'b1, 16'h0005, 16'h5555); check("ram_rdw_old", readdata, 16'h1234);
    tick();
    drive(1'b0, 16'h0005, 16'h0000); check("ram_rdw_new", readdata, 16'h5555);
    drive(1'b0, 16'hA705, 16'h0000); check("ram_hi_ignored", readdata, 16'h5555);
    drive(1'b1, 16'h0090, 16'h7777); tick();
    drive(1'b0, 16'h0090, 16'h0000); check("unmapped_90", readdata, 16'h0000);

    // OUTREG store, visible next cycle
    drive(1'b1, 16'h0081, 16'hC3A5); tick();
    drive(1'b0, 16'h0081, 16'h0000);
    check("switchout_load", switchout, 16'hC3A5);
    check("outreg_read", readdata, 16'hC3A5);

    // Debounce latency: stable 101 shows up exactly 18 cycles later
    drive(1'b0, 16'h0080, 16'h0000);
    switchin = 3'b101;
    for (int k = 1; k <= 18; k++) begin
      tick(); #1;
      check("swstat_track", readdata, exp_rd());
      if (k == 17) check("swstat_k17", readdata, 16'h0000);
    end
    check("swstat_k18", readdata, 16'h0005);
    drive(1'b0, 16'h0083, 16'h0000); check("swedge_rise", readdata, 16'h0005);

    // Glitch on bit1 shorter than the debounce window is rejected
    drive(1'b0, 16'h0080, 16'h0000);
    switchin = 3'b111;
    repeat (10) tick();
    switchin = 3'b101;
    repeat (20) begin tick(); #1; check("glitch_track", readdata, exp_rd()); end
    check("glitch_swstat", readdata, 16'h0005);
    drive(1'b0, 16'h0083, 16'h0000); check("glitch_swedge", readdata, 16'h0005);

    // Write-1-to-clear, then clear colliding with a new rise on bit2
    drive(1'b1, 16'h0083, 16'h0001); tick();
    drive(1'b0, 16'h0083, 16'h0000); check("swedge_clr0", readdata, 16'h0004);
    switchin = 3'b001;
    repeat (20) tick();
    drive(1'b0, 16'h0080, 16'h0000); check("swstat_fall", readdata, 16'h0001);
    switchin = 3'b101;
    repeat (17) tick();
    drive(1'b1, 16'h0083, 16'h0004); tick();
    drive(1'b0, 16'h0080, 16'h0000); check("swstat_rerise", readdata, 16'h0005);
    drive(1'b0, 16'h0083, 16'h0000); check("swedge_set_wins", readdata, 16'h0004);

    // Timer
`ifdef MIPS_IO_TIMER_EN
    drive(1'b0, 16'h0082, 16'h0000);
    check("timer_n", readdata, m_timer);
    t0 = m_timer;
    repeat (10) tick();
    #1 check("timer_n10", readdata, t0 + 16'd10);
    drive(1'b1, 16'h0082, 16'h1234); tick();
    drive(1'b0, 16'h0082, 16'h0000); check("timer_clr", readdata, 16'h0000);
    tick(); #1 check("timer_clr_next", readdata, 16'h0001);
    drive(1'b1, 16'h0082, 16'h0000); tick();
    drive(1'b0, 16'h0082, 16'h0000);
    repeat (65535) tick();
    #1 check("timer_ffff", readdata, 16'hFFFF);
    tick(); #1 check("timer_wrap", readdata, 16'h0000);
`else
    drive(1'b0, 16'h0082, 16'h0000); check("timer_absent", readdata, 16'h0000);
    drive(1'b1, 16'h0082, 16'hFFFF); tick();
    drive(1'b0, 16'h0082, 16'h0000); check("timer_absent_wr", readdata, 16'h0000);
    repeat (5) tick();
    #1 check("timer_absent_later", readdata, 16'h0000);
`endif

    // Fill RAM so every word has a known model value
    for (int i = 0; i < 128; i++) begin
      drive(1'b1, {$urandom_range(0, 255), 1'b0, 7'(i)}, 16'($urandom));
      tick();
    end

    // Randomized traffic against the model
    hold = 0;
    for (int n = 0; n < 600; n++) begin
      int r;
      if (hold == 0) begin
        switchin = 3'($urandom);
        hold = $urandom_range(1, 30);
      end
      hold--;
      r = $urandom_range(0, 9);
      ra = 16'($urandom);
      if (r <= 3)      ra[7] = 1'b0;
      else if (r <= 7) ra[7:0] = 8'h80 + 8'(r - 4);
      else if (r == 8) ra[7:0] = 8'($urandom_range(8'h84, 8'hFF));
      else             ra[7] = 1'b0;
      drive(1'($urandom_range(0, 1)), ra, 16'($urandom));
      check("rand_readdata", readdata, exp_rd());
      tick();
      check("rand_switchout", switchout, m_out);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
